// File: rtl/qim_pkg.sv
// Shared definitions for the QIM hypervector decoder: default geometry,
// derived widths and the controller state encoding.
package qim_pkg;

  localparam int HV_DIM_DEF  = 4096;
  localparam int M_DEF       = 16;
  localparam int CHUNK_W_DEF = 64;

  // Width needed to index n items; never narrower than one bit.
  function automatic int w_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int IDX_W       = w_of(M_DEF);
  localparam int SCORE_W     = $clog2(HV_DIM_DEF + 1);
  localparam int CHUNK_CNT_W = w_of(HV_DIM_DEF / CHUNK_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/qim_decoder_chunk_popcount.sv
// Combinational overlap count of one chunk: popcount(a AND b).
module chunk_popcount #(
  parameter int CHUNK_W = 64
) (
  input  logic [CHUNK_W-1:0]             a,
  input  logic [CHUNK_W-1:0]             b,
  output logic [$clog2(CHUNK_W+1)-1:0]   cnt
);

  localparam int CNT_W = $clog2(CHUNK_W + 1);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      cnt = cnt + CNT_W'(a[i] & b[i]);
    end
  end

endmodule

// File: rtl/qim_decoder.sv
// Sequential best-match search of a query hypervector against M item-memory
// entries, one chunk per cycle. Optional threshold hit flag: QIM_DEC_THRESH_EN.
module qim_decoder
  import qim_pkg::*;
#(
  parameter int HV_DIM  = HV_DIM_DEF,
  parameter int M       = M_DEF,
  parameter int CHUNK_W = CHUNK_W_DEF
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [M-1:0][HV_DIM-1:0]      im_hvs,
  input  logic                          query_valid,
  output logic                          query_ready,
  input  logic [HV_DIM-1:0]             query_hv,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [w_of(M)-1:0]            result_idx,
`ifdef QIM_DEC_THRESH_EN
  input  logic [$clog2(HV_DIM+1)-1:0]   match_thresh,
  output logic                          result_hit,
`endif
  output logic [$clog2(HV_DIM+1)-1:0]   result_score
);

  localparam int NCH        = HV_DIM / CHUNK_W;
  localparam int IDX_BITS   = w_of(M);
  localparam int SCORE_BITS = $clog2(HV_DIM + 1);
  localparam int CNT_BITS   = w_of(NCH);
  localparam int PC_W       = $clog2(CHUNK_W + 1);

  state_e                 state_q, state_d;
  logic [HV_DIM-1:0]      query_q;
  logic [IDX_BITS-1:0]    entry_q;
  logic [CNT_BITS-1:0]    chunk_q;
  logic [SCORE_BITS-1:0]  acc_q, best_score_q, total;
  logic [IDX_BITS-1:0]    best_idx_q;
  logic [CHUNK_W-1:0]     q_chunk, m_chunk;
  logic [PC_W-1:0]        pc;
  logic                   accept, last_chunk, last_entry;

  assign q_chunk    = query_q[chunk_q*CHUNK_W +: CHUNK_W];
  assign m_chunk    = im_hvs[entry_q][chunk_q*CHUNK_W +: CHUNK_W];
  assign total      = acc_q + SCORE_BITS'(pc);
  assign last_chunk = (chunk_q == CNT_BITS'(NCH - 1));
  assign last_entry = (entry_q == IDX_BITS'(M - 1));
  assign accept     = query_valid && query_ready;

  chunk_popcount #(.CHUNK_W(CHUNK_W)) u_popcount (
    .a   (q_chunk),
    .b   (m_chunk),
    .cnt (pc)
  );

  always_comb begin
    state_d      = state_q;
    query_ready  = (state_q == IDLE);
    result_valid = (state_q == DONE);
    case (state_q)
      IDLE:    if (query_valid) state_d = SCAN;
      SCAN:    if (last_chunk && last_entry) state_d = DONE;
      DONE:    if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Query (and threshold) capture: plain data, loaded only on accept.
  always_ff @(posedge clk) begin
    if (accept) query_q <= query_hv;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      entry_q      <= '0;
      chunk_q      <= '0;
      acc_q        <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
    end else if (accept) begin
      entry_q      <= '0;
      chunk_q      <= '0;
      acc_q        <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
    end else if (state_q == SCAN) begin
      if (last_chunk) begin
        // Strictly-greater update keeps the lowest index on ties.
        if (total > best_score_q) begin
          best_score_q <= total;
          best_idx_q   <= entry_q;
        end
        acc_q   <= '0;
        chunk_q <= '0;
        entry_q <= last_entry ? '0 : entry_q + 1'b1;
      end else begin
        acc_q   <= total;
        chunk_q <= chunk_q + 1'b1;
      end
    end
  end

  assign result_idx   = best_idx_q;
  assign result_score = best_score_q;

`ifdef QIM_DEC_THRESH_EN
  logic [SCORE_BITS-1:0] thresh_q;

  always_ff @(posedge clk) begin
    if (accept) thresh_q <= match_thresh;
  end

  assign result_hit = (state_q == DONE) && (best_score_q >= thresh_q);
`endif

endmodule

// File: tb/tb_qim_decoder.sv
// Directed-vector bench for qim_decoder at default geometry.
module tb_qim_decoder;
  import qim_pkg::*;

  localparam int HV = 4096;
  localparam int MM = 16;

  logic                 clk = 1'b0;
  logic                 nrst = 1'b0;
  logic [MM-1:0][HV-1:0] im_hvs = '0;
  logic                 query_valid = 1'b0;
  logic                 query_ready;
  logic [HV-1:0]        query_hv = '0;
  logic                 result_valid;
  logic                 result_ready = 1'b1;
  logic [3:0]           result_idx;
  logic [12:0]          result_score;
`ifdef QIM_DEC_THRESH_EN
  logic [12:0]          match_thresh = '0;
  logic                 result_hit;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  qim_decoder dut (
    .clk          (clk),
    .nrst         (nrst),
    .im_hvs       (im_hvs),
    .query_valid  (query_valid),
    .query_ready  (query_ready),
    .query_hv     (query_hv),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_idx   (result_idx),
`ifdef QIM_DEC_THRESH_EN
    .match_thresh (match_thresh),
    .result_hit   (result_hit),
`endif
    .result_score (result_score)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Accept one query, measure latency, check result and the return to IDLE.
  task automatic run_query(input string tag, input logic [HV-1:0] q,
                           input int exp_idx, input int exp_score,
                           input int thresh, input int exp_hit);
    int cnt;
    @(negedge clk);
    query_hv    = q;
    query_valid = 1'b1;
`ifdef QIM_DEC_THRESH_EN
    match_thresh = 13'(thresh);
`endif
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      if (cnt == 0) query_valid = 1'b0;
      cnt++;
    end while (!result_valid && cnt < 2000);
    check({tag, "_lat"}, cnt, 1025);
    check({tag, "_idx"}, result_idx, exp_idx);
    check({tag, "_score"}, result_score, exp_score);
`ifdef QIM_DEC_THRESH_EN
    check({tag, "_hit"}, result_hit, exp_hit);
`else
    if (thresh < 0 || exp_hit < 0) $display("note: negative threshold arguments ignored");
`endif
    @(posedge clk);
    #1;
    check({tag, "_idle"}, query_ready, 1);
  endtask

  logic [HV-1:0] q28, q29, q_ones;
  int b28[12] = '{0, 1, 63, 64, 100, 500, 1000, 2047, 2048, 3000, 4094, 4095};
  int b3[7]   = '{10, 20, 30, 70, 200, 1500, 4000};
  int b9[7]   = '{5, 600, 601, 2100, 3333, 3900, 4095};

  task automatic load_029();
    im_hvs = '0;
    q29    = '0;
    foreach (b3[i]) begin q29[b3[i]] = 1'b1; im_hvs[3][b3[i]] = 1'b1; end
    foreach (b9[i]) begin q29[b9[i]] = 1'b1; im_hvs[9][b9[i]] = 1'b1; end
    im_hvs[3][11] = 1'b1;
    im_hvs[3][21] = 1'b1;
    im_hvs[0][1]  = 1'b1;
    im_hvs[12][10] = 1'b1; im_hvs[12][20] = 1'b1; im_hvs[12][30] = 1'b1;
    im_hvs[12][5]  = 1'b1; im_hvs[12][600] = 1'b1;
  endtask

  task automatic load_028();
    im_hvs = '0;
    q28    = '0;
    foreach (b28[i]) im_hvs[5][b28[i]] = 1'b1;
    q28 = im_hvs[5];
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_valid", result_valid, 0);
    check("rst_idx", result_idx, 0);
    check("rst_score", result_score, 0);
    #22;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", query_ready, 1);

    // Single matching entry with 12 ones spread over several chunks
    load_028();
    run_query("match5", q28, 5, 12, 12, 1);

    // Tie between entries 3 and 9 resolves to 3; threshold boundary
    load_029();
    run_query("tie_t8", q29, 3, 7, 8, 0);
    run_query("tie_t7", q29, 3, 7, 7, 1);

    // All-zero query
    run_query("zero", '0, 0, 0, 1, 0);

    // Later larger entry wins; all-ones overlap reaches HV_DIM without overflow
    im_hvs = '0;
    for (int i = 0; i < 100; i++) im_hvs[2][i] = 1'b1;
    im_hvs[7] = '1;
    q_ones = '1;
    run_query("ones", q_ones, 7, 4096, 4096, 1);

    // Back-pressure and ignored queries during SCAN and DONE
    load_029();
    result_ready = 1'b0;
    @(negedge clk);
    query_hv    = q29;
    query_valid = 1'b1;
    @(negedge clk);
    query_valid = 1'b0;
    repeat (100) @(negedge clk);
    query_hv    = q_ones;
    query_valid = 1'b1;
    #1;
    check("bp_scan_ready", query_ready, 0);
    @(negedge clk);
    query_valid = 1'b0;
    begin
      int n = 0;
      while (!result_valid && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check("bp_done_seen", result_valid, 1);
    end
    query_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", result_valid, 1);
      check("bp_hold_idx", result_idx, 3);
      check("bp_hold_score", result_score, 7);
    end
    query_valid = 1'b0;
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_rel_valid", result_valid, 0);
    check("bp_rel_ready", query_ready, 1);

    // Asynchronous reset midway through SCAN, then a clean decode
    load_028();
    @(negedge clk);
    query_hv    = q28;
    query_valid = 1'b1;
    @(negedge clk);
    query_valid = 1'b0;
    repeat (500) @(posedge clk);
    #3;
    nrst = 1'b0;
    #1;
    check("mid_rst_valid", result_valid, 0);
    check("mid_rst_ready", query_ready, 1);
    check("mid_rst_idx", result_idx, 0);
    check("mid_rst_score", result_score, 0);
    @(negedge clk);
    nrst = 1'b1;
    load_029();
    run_query("post_rst", q29, 3, 7, 7, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
